// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the MEM-stage load/store engine: load-enable
// encodings, access sizes, exception cause codes, LSU FSM states and the
// registered bus-request bundle.
// ---------------------------------------------------------------------------
package riscv_pkg;

   // i_ld_en encodings (anything else means "no load")
   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LH   = 3'd2;
   localparam logic [2:0] LD_LW   = 3'd3;
   localparam logic [2:0] LD_LBU  = 3'd4;
   localparam logic [2:0] LD_LHU  = 3'd5;

   // access sizes (same encoding as instr[13:12] for stores)
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // trap cause codes
   localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
   localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
   localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
   localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   // access captured in IDLE and held stable on the bus during WAIT
   typedef struct packed {
      logic [31:0] addr;   // full byte address (low bits give the lane)
      logic [1:0]  size;
      logic        sign;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  bmask;
   } lsu_req_t;

   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] lo);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// ---------------------------------------------------------------------------
// lsu_load_fmt
// Combinational load-data formatter: selects the byte/half lane of a read
// word and sign- or zero-extends it; words pass through.
//   i_rdata  32  raw read word
//   i_lane    2  byte address bits [1:0]
//   i_size    2  SZ_B / SZ_H / SZ_W
//   i_sign    1  1 = sign-extend (LB/LH)
//   o_data   32  formatted load value
// ---------------------------------------------------------------------------
module lsu_load_fmt
   import riscv_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_sign,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_lane)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

      o_data = i_rdata;
      case (i_size)
         SZ_B:    o_data = {{24{i_sign & w_byte[7]}}, w_byte};
         SZ_H:    o_data = {{16{i_sign & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store engine. Takes the EX/MEM bundle, runs one access at a
// time on a req/ack data bus, stalls the pipeline while it is outstanding,
// formats load data and reports misaligned / timed-out accesses.
//   i_clk, i_rst            clock, async active-high reset
//   i_insn_vld, i_instr     EX/MEM valid and instruction (store size [13:12])
//   i_alu_data, i_rs2_data  effective address, store data
//   i_ld_en, i_lsu_wren     load type / store request
//   i_kill                  squash EX/MEM (only looked at in IDLE)
//   o_stall                 hold the front of the pipeline
//   o_ld_data, o_mem_done   formatted load value, completion pulse
//   o_exc, o_exc_cause/tval exception pulse, cause, faulting address
//   o_dmem_*, i_dmem_*      data-memory bus
// ---------------------------------------------------------------------------
module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_insn_vld,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_alu_data,
   input  logic [31:0] i_rs2_data,
   input  logic [2:0]  i_ld_en,
   input  logic        i_lsu_wren,
   input  logic        i_kill,
   output logic        o_stall,
   output logic [31:0] o_ld_data,
   output logic        o_mem_done,
   output logic        o_exc,
   output logic [3:0]  o_exc_cause,
   output logic [31:0] o_exc_tval,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_bmask,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e     r_state, w_next;
   lsu_req_t       r_req, w_req;
   logic [CW-1:0]  r_cnt;
   logic [31:0]    r_ld_data, r_exc_tval;
   logic [3:0]     r_exc_cause;
   logic           r_exc, r_fault;

   logic           w_is_load, w_access, w_mis, w_timeout;
   logic [1:0]     w_size;
   logic [31:0]    w_fmt;
   logic           w_unused_instr;

   assign w_unused_instr = ^{i_instr[31:14], i_instr[11:0]};

   // ---- decode of the presented access (store wins over load) ----
   assign w_is_load = (i_ld_en >= LD_LB) && (i_ld_en <= LD_LHU);
   assign w_access  = i_insn_vld & ~i_kill & (w_is_load | i_lsu_wren);

   always_comb begin
      w_size = SZ_W;
      if (i_lsu_wren)
         w_size = (i_instr[13:12] == 2'b11) ? SZ_W : i_instr[13:12];
      else if (i_ld_en == LD_LB || i_ld_en == LD_LBU)
         w_size = SZ_B;
      else if (i_ld_en == LD_LH || i_ld_en == LD_LHU)
         w_size = SZ_H;
   end

   assign w_mis = is_misaligned(w_size, i_alu_data[1:0]);

   always_comb begin
      w_req       = '0;
      w_req.addr  = i_alu_data;
      w_req.size  = w_size;
      w_req.sign  = ~i_lsu_wren & ((i_ld_en == LD_LB) | (i_ld_en == LD_LH));
      w_req.we    = i_lsu_wren;
      case (w_size)
         SZ_B: begin
            w_req.wdata = {4{i_rs2_data[7:0]}};
            w_req.bmask = 4'b0001 << i_alu_data[1:0];
         end
         SZ_H: begin
            w_req.wdata = {2{i_rs2_data[15:0]}};
            w_req.bmask = 4'b0011 << {i_alu_data[1], 1'b0};
         end
         default: begin
            w_req.wdata = i_rs2_data;
            w_req.bmask = 4'b1111;
         end
      endcase
   end

   lsu_load_fmt u_fmt (
      .i_rdata (i_dmem_rdata),
      .i_lane  (r_req.addr[1:0]),
      .i_size  (r_req.size),
      .i_sign  (r_req.sign),
      .o_data  (w_fmt)
   );

   // ack on the last allowed cycle still counts as a completion
   assign w_timeout = (r_state == ST_WAIT) & ~i_dmem_ack &
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   // ---- FSM next state / combinational outputs ----
   always_comb begin
      w_next     = r_state;
      o_stall    = 1'b0;
      o_dmem_req = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_access && !w_mis) begin
               o_stall = 1'b1;
               w_next  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            o_stall    = 1'b1;
            o_dmem_req = 1'b1;
            if (i_dmem_ack || w_timeout)
               w_next = ST_RESP;
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // ---- state and datapath registers ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_req       <= '0;
         r_cnt       <= '0;
         r_ld_data   <= '0;
         r_exc       <= 1'b0;
         r_exc_cause <= '0;
         r_exc_tval  <= '0;
         r_fault     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_exc   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cnt   <= '0;
               r_fault <= 1'b0;
               if (w_access) begin
                  if (w_mis) begin
                     r_exc       <= 1'b1;
                     r_exc_cause <= i_lsu_wren ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                     r_exc_tval  <= i_alu_data;
                  end else begin
                     r_req <= w_req;
                  end
               end
            end
            ST_WAIT: begin
               if (i_dmem_ack) begin
                  if (!r_req.we)
                     r_ld_data <= w_fmt;
               end else if (w_timeout) begin
                  r_exc       <= 1'b1;
                  r_fault     <= 1'b1;
                  r_exc_cause <= r_req.we ? EXC_ST_FAULT : EXC_LD_FAULT;
                  r_exc_tval  <= r_req.addr;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ld_data    = r_ld_data;
   assign o_mem_done   = (r_state == ST_RESP) & ~r_fault;
   assign o_exc        = r_exc;
   assign o_exc_cause  = r_exc_cause;
   assign o_exc_tval   = r_exc_tval;
   assign o_dmem_we    = r_req.we;
   assign o_dmem_addr  = {r_req.addr[31:2], 2'b00};
   assign o_dmem_wdata = r_req.wdata;
   assign o_dmem_bmask = r_req.bmask;

endmodule
